// File: rtl/dm_pkg.sv
// Shared types and constants for the dm_banked data memory and its lane logic.
package dm_pkg;

    localparam int DM_DEPTH_DEFAULT = 1024;

    // 2'b11 has no member: it is the reserved size and is reported as an error.
    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10
    } dm_size_e;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } dm_state_e;

endpackage

// File: rtl/dm_banked_if.sv
// Request/response bus of the data memory; the requester is the master.
interface dm_banked_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

endinterface

// File: rtl/dm_lane.sv
// Byte-lane logic: store byte enables and replicated store word, alignment check,
// and load extraction with sign/zero extension.
module dm_lane
    import dm_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wword,
    output logic        misaligned,
    output logic [31:0] rdata
);

    logic [31:0] shifted;

    // NOTE: every output gets a default before the case so no path leaves one unassigned (no latch).
    always_comb begin
        be         = '0;
        wword      = '0;
        misaligned = 1'b0;
        rdata      = '0;
        shifted    = rword >> {offset, 3'b000};
        case (size)
            SZ_B: begin
                be    = 4'b0001 << offset;
                wword = {4{wdata[7:0]}};
                rdata = {{24{~is_unsigned & shifted[7]}}, shifted[7:0]};
            end
            SZ_H: begin
                be         = offset[1] ? 4'b1100 : 4'b0011;
                wword      = {2{wdata[15:0]}};
                misaligned = offset[0];
                rdata      = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
            end
            SZ_W: begin
                be         = 4'b1111;
                wword      = wdata;
                misaligned = |offset;
                rdata      = rword;
            end
            default: misaligned = 1'b1;  // reserved size is treated as unusable alignment
        endcase
    end

endmodule

// File: rtl/dm_banked.sv
// Byte-addressable 32-bit data memory with a zero-fill INIT sequence and a
// fixed READ_LAT response pipeline (1 or 2 cycles).
module dm_banked
    import dm_pkg::*;
#(
    parameter int DEPTH          = DM_DEPTH_DEFAULT,
    parameter int READ_LAT       = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic         clk,
    input  logic         rst,
    dm_banked_if.slave   bus
);

    localparam int AW = $clog2(DEPTH);

    logic [31:0]   mem [DEPTH];
    dm_state_e     state, state_nxt;
    logic [AW-1:0] clr_cnt;
    logic          ready, busy;

    logic [AW-1:0] idx;
    logic          oor, misaligned, err, accept, wr_en;
    logic [3:0]    be;
    logic [31:0]   wword, lane_rdata;

    assign idx    = bus.req_addr[AW+1:2];
    assign oor    = |bus.req_addr[31:AW+2];
    assign accept = bus.req_valid & ready;
    assign err    = oor | misaligned;
    assign wr_en  = accept & bus.req_we & ~err;

    dm_lane u_lane (
        .size        (bus.req_size),
        .offset      (bus.req_addr[1:0]),
        .is_unsigned (bus.req_unsigned),
        .wdata       (bus.req_wdata),
        .rword       (mem[idx]),
        .be          (be),
        .wword       (wword),
        .misaligned  (misaligned),
        .rdata       (lane_rdata)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= (CLEAR_ON_RESET != 0) ? ST_INIT : ST_RUN;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        busy      = 1'b0;
        case (state)
            ST_INIT: begin
                busy = 1'b1;
                if (clr_cnt == AW'(DEPTH - 1)) state_nxt = ST_RUN;
            end
            // Gating with rst keeps the port closed while reset is held in RUN.
            ST_RUN:  ready = rst;
            default: state_nxt = ST_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                 clr_cnt <= '0;
        else if (state == ST_INIT) clr_cnt <= clr_cnt + 1'b1;
    end

    // NOTE: the array has no reset; zeroing happens only through the INIT walk.
    always_ff @(posedge clk) begin
        if (state == ST_INIT) begin
            mem[clr_cnt] <= '0;
        end else if (wr_en) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) mem[idx][8*b +: 8] <= wword[8*b +: 8];
        end
    end

    // Load data is captured at acceptance, so a store in an earlier cycle is always visible.
    logic        p1_valid, p1_err;
    logic [31:0] p1_rdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p1_valid <= 1'b0;
            p1_err   <= 1'b0;
            p1_rdata <= '0;
        end else begin
            p1_valid <= accept;
            p1_err   <= accept & err;
            p1_rdata <= (accept & ~bus.req_we & ~err) ? lane_rdata : '0;
        end
    end

    generate
        if (READ_LAT == 2) begin : g_lat2
            logic        p2_valid, p2_err;
            logic [31:0] p2_rdata;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    p2_valid <= 1'b0;
                    p2_err   <= 1'b0;
                    p2_rdata <= '0;
                end else begin
                    p2_valid <= p1_valid;
                    p2_err   <= p1_err;
                    p2_rdata <= p1_rdata;
                end
            end
            assign bus.rsp_valid = p2_valid;
            assign bus.rsp_err   = p2_err;
            assign bus.rsp_rdata = p2_rdata;
        end else begin : g_lat1
            assign bus.rsp_valid = p1_valid;
            assign bus.rsp_err   = p1_err;
            assign bus.rsp_rdata = p1_rdata;
        end
    endgenerate

    assign bus.req_ready = ready;
    assign bus.busy      = busy;

endmodule

// File: tb/tb_dm_banked.sv
// Directed bench: instance A (DEPTH=16, READ_LAT=1) and instance B (DEPTH=1024, READ_LAT=2).
module tb_dm_banked;

    logic clk;
    logic rst;
    int   checks;
    int   passes;

    dm_banked_if ia ();
    dm_banked_if ib ();

    dm_banked #(.DEPTH(16), .READ_LAT(1), .CLEAR_ON_RESET(1)) u_a (
        .clk (clk),
        .rst (rst),
        .bus (ia.slave)
    );

    dm_banked #(.DEPTH(1024), .READ_LAT(2), .CLEAR_ON_RESET(1)) u_b (
        .clk (clk),
        .rst (rst),
        .bus (ib.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [33:0] obs, input logic [33:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=0x%09h expected=0x%09h", tag, obs, exp);
    endtask

    // Instance A: drive one request at a negedge; the response is due one edge later.
    task automatic req_a(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err, input string tag);
        ia.req_valid    = 1'b1;
        ia.req_we       = we;
        ia.req_size     = sz;
        ia.req_unsigned = uns;
        ia.req_addr     = addr;
        ia.req_wdata    = wdata;
        @(negedge clk);
        ia.req_valid = 1'b0;
        check(tag, {ia.rsp_valid, ia.rsp_err, ia.rsp_rdata}, {1'b1, exp_err, exp_rdata});
    endtask

    // Instance B: response must be absent after one edge and present after two.
    task automatic req_b(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err, input string tag);
        ib.req_valid    = 1'b1;
        ib.req_we       = we;
        ib.req_size     = sz;
        ib.req_unsigned = uns;
        ib.req_addr     = addr;
        ib.req_wdata    = wdata;
        @(negedge clk);
        ib.req_valid = 1'b0;
        check({tag, "_early"}, {ib.rsp_valid, ib.rsp_err, ib.rsp_rdata}, 34'h0);
        @(negedge clk);
        check(tag, {ib.rsp_valid, ib.rsp_err, ib.rsp_rdata}, {1'b1, exp_err, exp_rdata});
    endtask

    initial begin
        int n;
        checks = 0;
        passes = 0;
        rst = 1'b0;
        {ia.req_valid, ia.req_we, ia.req_size, ia.req_unsigned, ia.req_addr, ia.req_wdata} = '0;
        {ib.req_valid, ib.req_we, ib.req_size, ib.req_unsigned, ib.req_addr, ib.req_wdata} = '0;
        repeat (2) @(negedge clk);

        check("reset_a", 34'({ia.rsp_valid, ia.rsp_err, ia.rsp_rdata != 0, ia.req_ready, ia.busy}), 34'b00001);
        check("reset_b", 34'({ib.rsp_valid, ib.rsp_err, ib.rsp_rdata != 0, ib.req_ready, ib.busy}), 34'b00001);

        rst = 1'b1;
        n = 0;
        while (ia.busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("init_cycles_a", 34'(n), 34'd16);
        check("ready_after_init_a", 34'({ia.req_ready, ia.busy}), 34'b10);

        req_a(1'b0, 2'b10, 1'b0, 32'h0000_003C, 32'h0, 32'h0, 1'b0, "lw_cleared_3c");
        req_a(1'b0, 2'b00, 1'b0, 32'h0000_0001, 32'h0, 32'h0, 1'b0, "lb_cleared_1");

        req_a(1'b1, 2'b10, 1'b0, 32'h0000_0008, 32'h1122_3344, 32'h0, 1'b0, "sw_8");
        req_a(1'b0, 2'b00, 1'b1, 32'h0000_0009, 32'h0, 32'h0000_0033, 1'b0, "lbu_9");
        req_a(1'b0, 2'b00, 1'b0, 32'h0000_000B, 32'h0, 32'h0000_0011, 1'b0, "lb_b");
        req_a(1'b0, 2'b01, 1'b1, 32'h0000_000A, 32'h0, 32'h0000_1122, 1'b0, "lhu_a");
        req_a(1'b0, 2'b01, 1'b0, 32'h0000_0008, 32'h0, 32'h0000_3344, 1'b0, "lh_8");

        req_a(1'b1, 2'b10, 1'b0, 32'h0000_0004, 32'hFFFF_FFFF, 32'h0, 1'b0, "sw_4_ones");
        req_a(1'b1, 2'b00, 1'b0, 32'h0000_0005, 32'hAAAA_AA80, 32'h0, 1'b0, "sb_5");
        req_a(1'b0, 2'b00, 1'b0, 32'h0000_0005, 32'h0, 32'hFFFF_FF80, 1'b0, "lb_5");
        req_a(1'b0, 2'b00, 1'b1, 32'h0000_0005, 32'h0, 32'h0000_0080, 1'b0, "lbu_5");
        req_a(1'b0, 2'b10, 1'b0, 32'h0000_0004, 32'h0, 32'hFFFF_80FF, 1'b0, "lw_4");
        req_a(1'b0, 2'b01, 1'b0, 32'h0000_0006, 32'h0, 32'hFFFF_FFFF, 1'b0, "lh_6");
        req_a(1'b0, 2'b01, 1'b1, 32'h0000_0004, 32'h0, 32'h0000_80FF, 1'b0, "lhu_4");

        req_a(1'b1, 2'b01, 1'b0, 32'h0000_0003, 32'h0000_BEEF, 32'h0, 1'b1, "sh_3_misaligned");
        req_a(1'b0, 2'b10, 1'b0, 32'h0000_0002, 32'h0, 32'h0, 1'b1, "lw_2_misaligned");
        req_a(1'b0, 2'b10, 1'b0, 32'h0000_0000, 32'h0, 32'h0, 1'b0, "lw_0_unchanged");
        req_a(1'b0, 2'b11, 1'b0, 32'h0000_0000, 32'h0, 32'h0, 1'b1, "reserved_size");
        req_a(1'b0, 2'b10, 1'b0, 32'h0000_0040, 32'h0, 32'h0, 1'b1, "lw_40_oor");
        req_a(1'b1, 2'b10, 1'b0, 32'h0000_0040, 32'hDEAD_BEEF, 32'h0, 1'b1, "sw_40_oor");
        req_a(1'b0, 2'b10, 1'b0, 32'h0000_0000, 32'h0, 32'h0, 1'b0, "lw_0_no_alias");
        @(negedge clk);
        check("rsp_pulse_a", {ia.rsp_valid, ia.rsp_err, ia.rsp_rdata}, 34'h0);

        n = 0;
        while (ib.busy && n < 2000) begin
            n++;
            @(negedge clk);
        end
        check("ready_after_init_b", 34'({ib.req_ready, ib.busy}), 34'b10);
        req_b(1'b0, 2'b10, 1'b0, 32'h0000_1000, 32'h0, 32'h0, 1'b1, "lw_1000_oor");
        req_b(1'b0, 2'b10, 1'b0, 32'h0000_0FFC, 32'h0, 32'h0, 1'b0, "lw_ffc_cleared");

        // Store then load to the same word on consecutive cycles.
        ib.req_valid = 1'b1; ib.req_we = 1'b1; ib.req_size = 2'b10; ib.req_unsigned = 1'b0;
        ib.req_addr = 32'h0000_0010; ib.req_wdata = 32'hCAFE_F00D;
        @(negedge clk);
        ib.req_we = 1'b0; ib.req_wdata = 32'h0;
        check("b2b_idle", {ib.rsp_valid, ib.rsp_err, ib.rsp_rdata}, 34'h0);
        @(negedge clk);
        ib.req_valid = 1'b0;
        check("b2b_store_rsp", {ib.rsp_valid, ib.rsp_err, ib.rsp_rdata}, {2'b10, 32'h0});
        @(negedge clk);
        check("b2b_load_rsp", {ib.rsp_valid, ib.rsp_err, ib.rsp_rdata}, {2'b10, 32'hCAFE_F00D});
        req_b(1'b0, 2'b00, 1'b1, 32'h0000_0013, 32'h0, 32'h0000_00CA, 1'b0, "lbu_13");

        // Reset while a load to instance A is in flight.
        ia.req_valid = 1'b1; ia.req_we = 1'b0; ia.req_size = 2'b10; ia.req_unsigned = 1'b0;
        ia.req_addr = 32'h0000_0008;
        @(posedge clk);
        #1 rst = 1'b0;
        ia.req_valid = 1'b0;
        #1 check("rst_inflight", 34'({ia.rsp_valid, ia.req_ready, ia.busy}), 34'b001);
        @(negedge clk);
        check("rst_held", {ia.rsp_valid, ia.rsp_err, ia.rsp_rdata}, 34'h0);
        rst = 1'b1;
        n = 0;
        while (ia.busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("reinit_cycles_a", 34'(n), 34'd16);
        req_a(1'b0, 2'b10, 1'b0, 32'h0000_0008, 32'h0, 32'h0, 1'b0, "lw_8_recleared");
        req_a(1'b0, 2'b10, 1'b0, 32'h0000_0004, 32'h0, 32'h0, 1'b0, "lw_4_recleared");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/dm_banked.md
DM_BANKED -- requirements
Module: dm_banked

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, meaning number of 32-bit words; power of two, at least 4.
REQ-002 SHALL have parameter READ_LAT, default 1, meaning request-to-response latency in cycles; legal values are 1 and 2.
REQ-003 SHALL have parameter CLEAR_ON_RESET, default 1, meaning the array is zero-filled after reset (1) or not cleared (0).
REQ-004 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req_valid  input  1  request present.
REQ-007 SHALL have port req_ready  output  1  request accepted this cycle when high with req_valid.
REQ-008 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-009 SHALL have port req_size  input  2  access size: 00 = byte, 01 = half, 10 = word; 11 is reserved.
REQ-010 SHALL have port req_unsigned  input  1  zero-extend load (1) or sign-extend load (0).
REQ-011 SHALL have port req_addr  input  32  byte address.
REQ-012 SHALL have port req_wdata  input  32  store data, right-aligned.
REQ-013 SHALL have port rsp_valid  output  1  response present; one-cycle pulse.
REQ-014 SHALL have port rsp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-015 SHALL have port rsp_err  output  1  access was misaligned, out of range or reserved size.
REQ-016 SHALL have port busy  output  1  clear sequence in progress.

Function
REQ-017 SHALL implement FSM states INIT and RUN: reset enters INIT if CLEAR_ON_RESET=1, else RUN; INIT moves to RUN after the clear counter reaches DEPTH-1.
REQ-018 SHALL, in INIT, write zero to word index = clear counter each cycle (DEPTH cycles total), hold req_ready=0 and busy=1.
REQ-019 SHALL drive req_ready=1 and busy=0 in RUN; a request is accepted on any RUN cycle with req_valid=1; no back-pressure on responses.
REQ-020 SHALL use word index = req_addr[log2(DEPTH)+1:2]; the access is out of range if any of req_addr[31:log2(DEPTH)+2] is nonzero.
REQ-021 SHALL flag an error for half accesses with addr[0]=1, word accesses with addr[1:0]!=0, size 11, or out-of-range addresses; an errored store SHALL NOT modify the array.
REQ-022 SHALL perform stores little-endian with byte enables set by size and addr[1:0]: byte writes lane addr[1:0] with wdata[7:0]; half writes lanes addr[1]*2 and +1 with wdata[15:0]; word writes all lanes. The array SHALL be updated at the accepting edge.
REQ-023 SHALL extract the addressed byte/half/word from the read word on loads and extend it per req_unsigned to 32 bits.
REQ-024 SHALL assert rsp_valid exactly READ_LAT cycles after each accepted request (load or store), carrying that request's rsp_err and rsp_rdata; responses stay in request order.
REQ-025 SHALL return post-store data for a load accepted in any cycle after a store to the same word (no stale read hazard at either READ_LAT).
REQ-026 SHALL accept back-to-back requests every cycle with throughput 1 per cycle.

Reset
REQ-027 SHALL, on rst low, immediately (asynchronously) clear rsp_valid, rsp_err and rsp_rdata to 0, clear the pipeline valid bits and the clear counter to 0, drive req_ready=0, and set busy=CLEAR_ON_RESET.
REQ-028 SHALL discard in-flight responses when reset is asserted mid-operation or mid-INIT; INIT SHALL restart from index 0 after release.
REQ-029 SHALL NOT asynchronously reset the array contents; zeroing occurs only through INIT.

Structure
REQ-030 SHALL place the size encoding enum (SZ_B, SZ_H, SZ_W) and the default DEPTH constant in shared package dm_pkg.
REQ-031 SHALL contain one combinational sub-module dm_lane that computes byte enables, the lane-shifted store word, the misalignment flag and load extraction/extension.

Verification
REQ-032 SHALL cover: reset release with DEPTH=16 -> busy high for exactly 16 cycles, then req_ready=1; a load of any address returns 0.
REQ-033 SHALL cover: store word 0x11223344 @0x8, then lbu @0x9, lb @0xB and lhu @0xA -> 0x00000033, 0x00000011 and 0x00001122 respectively.
REQ-034 SHALL cover: store byte 0x80 @0x5 over an existing 0xFFFFFFFF word, then lb @0x5 -> 0xFFFFFF80 and lw @0x4 -> 0xFFFF80FF.
REQ-035 SHALL cover: store half @0x3 and lw @0x2 -> rsp_err=1 and rdata 0, with the array unchanged; with DEPTH=1024, an access @0x1000 -> rsp_err=1.
REQ-036 SHALL cover: with READ_LAT=2, a store @0x10 followed by a lw @0x10 in the next cycle -> the load response returns the new data 2 cycles after acceptance.
REQ-037 SHALL cover: rst asserted with a load in flight -> rsp_valid stays 0 and INIT restarts at index 0.
